// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bus: stall/redirect control, instruction-memory port, IF/ID pair.
// master = fetch unit side; slave = pipeline / memory / bench side.
// Pure wiring bundle with no state.
interface if_fetch_unit_if #(
    parameter int PC_W = 32
);
    logic            stay;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [31:0]     PCp4_o;
    logic [31:0]     ins_o;
    logic            valid_o;

    modport master (
        input  stay, redirect, redirect_pc, imem_rdata,
        output imem_req, imem_addr, PCp4_o, ins_o, valid_o
    );

    modport slave (
        output stay, redirect, redirect_pc, imem_rdata,
        input  imem_req, imem_addr, PCp4_o, ins_o, valid_o
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, reads 1-cycle imem, presents {PC+4, ins} to IF/ID.
// Latency: issue in cycle t is presented in cycle t+1; redirect costs 2 bubbles.
// Backpressure: stay holds the PC and parks the in-flight response in a 1-entry
// buffer. Optional perf counters are enabled by defining IF_FETCH_PERF_CNT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    if_fetch_unit_if.master      bus
`ifdef IF_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]          fetch_cnt_o,
    output logic [31:0]          stall_cnt_o
`endif
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_next;
    logic            inflight_v;
    logic [PC_W-1:0] inflight_pcp4;
    logic            buf_v;
    logic [31:0]     buf_ins;
    logic [PC_W-1:0] buf_pcp4;
    logic            issue;

    assign issue         = reset & ~bus.stay & ~bus.redirect;
    assign pc_next       = pc_q + PC_W'(4);
    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc_q;

    // Output select: parked buffer first, then the live memory response.
    // A redirect kills whatever would have been presented this cycle.
    always_comb begin
        bus.valid_o = 1'b0;
        bus.PCp4_o  = 32'h0;
        bus.ins_o   = 32'h0;
        if (reset && !bus.redirect) begin
            if (buf_v) begin
                bus.valid_o = 1'b1;
                bus.PCp4_o  = 32'(buf_pcp4);
                bus.ins_o   = buf_ins;
            end else if (inflight_v) begin
                bus.valid_o = 1'b1;
                bus.PCp4_o  = 32'(inflight_pcp4);
                bus.ins_o   = bus.imem_rdata;
            end
        end
    end

    // PC, in-flight tracking and stall buffer; reset beats redirect beats stay.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q       <= RESET_PC[PC_W-1:0];
            inflight_v <= 1'b0;
            buf_v      <= 1'b0;
        end else if (bus.redirect) begin
            pc_q       <= {bus.redirect_pc[PC_W-1:2], 2'b00};
            inflight_v <= 1'b0;
            buf_v      <= 1'b0;
        end else if (bus.stay) begin
            inflight_v <= 1'b0;
            // The memory data is only valid for one cycle, so park it now.
            if (inflight_v && !buf_v) begin
                buf_v    <= 1'b1;
                buf_ins  <= bus.imem_rdata;
                buf_pcp4 <= inflight_pcp4;
            end
        end else begin
            pc_q          <= pc_next;
            inflight_v    <= 1'b1;
            inflight_pcp4 <= pc_next;
            buf_v         <= 1'b0;
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    // Delivered-instruction and stall-cycle counters, free-running with wrap.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_cnt_o <= 32'h0;
            stall_cnt_o <= 32'h0;
        end else begin
            if (bus.valid_o && !bus.stay && !bus.redirect)
                fetch_cnt_o <= fetch_cnt_o + 32'h1;
            if (bus.stay && !bus.redirect)
                stall_cnt_o <= stall_cnt_o + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a queued expected-response scoreboard.
// Each driven cycle pushes its expected outputs; the negedge monitor pops and compares.
// Memory model returns addr^A5A5_0000 after a request and junk otherwise.
module tb_if_fetch_unit;

    logic clk;
    logic reset;
    logic [31:0] rdata_q;

    if_fetch_unit_if #(.PC_W(32)) bus ();

`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef IF_FETCH_PERF_CNT_EN
        ,
        .fetch_cnt_o (fetch_cnt),
        .stall_cnt_o (stall_cnt)
`endif
    );

    typedef struct {
        string       tag;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pcp4;
        logic [31:0] ins;
        logic        chk_cnt;
        logic [31:0] fcnt;
        logic [31:0] scnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 0;

    function automatic logic [31:0] m(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data after a request, junk otherwise.
    always @(posedge clk) begin
        if (bus.imem_req) rdata_q <= m(bus.imem_addr);
        else              rdata_q <= 32'hDEAD_BEEF;
    end
    assign bus.imem_rdata = rdata_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic cyc(input string tag, input logic r, input logic s, input logic rd,
                       input logic [31:0] rpc, input logic ereq, input logic [31:0] eaddr,
                       input logic evld, input logic [31:0] ep, input logic [31:0] ei);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = r;
        bus.stay        = s;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        e.tag = tag; e.req = ereq; e.addr = eaddr; e.vld = evld;
        e.pcp4 = ep; e.ins = ei; e.chk_cnt = 1'b0; e.fcnt = 0; e.scnt = 0;
        exp_q.push_back(e);
    endtask

    task automatic cnt_expect(input logic [31:0] f, input logic [31:0] s);
        exp_q[$].chk_cnt = 1'b1;
        exp_q[$].fcnt    = f;
        exp_q[$].scnt    = s;
    endtask

    // Monitor: compare every driven cycle against its queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, ".imem_req"}, 32'(bus.imem_req), 32'(e.req));
            if (e.req) chk({e.tag, ".imem_addr"}, bus.imem_addr, e.addr);
            chk({e.tag, ".valid_o"}, 32'(bus.valid_o), 32'(e.vld));
            chk({e.tag, ".PCp4_o"}, bus.PCp4_o, e.pcp4);
            chk({e.tag, ".ins_o"}, bus.ins_o, e.ins);
            if (bus.valid_o) chk({e.tag, ".never_mem10"}, 32'(bus.ins_o == m(32'h10)), 32'h0);
`ifdef IF_FETCH_PERF_CNT_EN
            if (e.chk_cnt) begin
                chk({e.tag, ".fetch_cnt"}, fetch_cnt, e.fcnt);
                chk({e.tag, ".stall_cnt"}, stall_cnt, e.scnt);
            end
`endif
        end
    end

    initial begin
        reset           = 1'b0;
        bus.stay        = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        rdata_q         = 32'h0;
        // reset held
        cyc("rst0", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("rst1", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // streaming from RESET_PC
        cyc("c1",  1, 0, 0, 0, 1, 32'h0,   0, 32'h0,  32'h0);
        cyc("c2",  1, 0, 0, 0, 1, 32'h4,   1, 32'h4,  m(32'h0));
        cyc("c3",  1, 0, 0, 0, 1, 32'h8,   1, 32'h8,  m(32'h4));
        // 3-cycle stall right after issuing 0x8
        cyc("st1", 1, 1, 0, 0, 0, 32'h0,   1, 32'hC,  m(32'h8));
        cyc("st2", 1, 1, 0, 0, 0, 32'h0,   1, 32'hC,  m(32'h8));
        cyc("st3", 1, 1, 0, 0, 0, 32'h0,   1, 32'hC,  m(32'h8));
        cyc("rel", 1, 0, 0, 0, 1, 32'hC,   1, 32'hC,  m(32'h8));
        cyc("c8",  1, 0, 0, 0, 1, 32'h10,  1, 32'h10, m(32'hC));
        // redirect with 0x10 in flight
        cyc("rd0", 1, 0, 1, 32'h100, 0, 32'h0, 0, 32'h0, 32'h0);
        cyc("rd1", 1, 0, 0, 0, 1, 32'h100, 0, 32'h0,   32'h0);
        cyc("rd2", 1, 0, 0, 0, 1, 32'h104, 1, 32'h104, m(32'h100));
        // stall, then redirect to unaligned target during stall
        cyc("s12", 1, 1, 0, 0, 0, 32'h0,   1, 32'h108, m(32'h104));
        cyc("rds", 1, 1, 1, 32'h203, 0, 32'h0, 0, 32'h0, 32'h0);
        cyc("s14", 1, 1, 0, 0, 0, 32'h0,   0, 32'h0,   32'h0);
        cyc("s15", 1, 0, 0, 0, 1, 32'h200, 0, 32'h0,   32'h0);
        cyc("s16", 1, 0, 0, 0, 1, 32'h204, 1, 32'h204, m(32'h200));
        // PC wrap
        cyc("w0",  1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 32'h0);
        cyc("w1",  1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
        cyc("w2",  1, 0, 0, 0, 1, 32'h0,   1, 32'h0,   m(32'hFFFF_FFFC));
        cyc("w3",  1, 0, 0, 0, 1, 32'h4,   1, 32'h4,   m(32'h0));
        // mid-stall reset
        cyc("m0",  1, 1, 0, 0, 0, 32'h0,   1, 32'h8,   m(32'h4));
        cnt_expect(32'd8, 32'd5);
        cyc("m1",  0, 1, 0, 0, 0, 32'h0,   0, 32'h0,   32'h0);
        cyc("m2",  1, 1, 0, 0, 0, 32'h0,   0, 32'h0,   32'h0);
        cnt_expect(32'd0, 32'd0);
        cyc("m3",  1, 0, 0, 0, 1, 32'h0,   0, 32'h0,   32'h0);
        cyc("m4",  1, 0, 0, 0, 1, 32'h4,   1, 32'h4,   m(32'h0));
        cyc("m5",  1, 0, 0, 0, 1, 32'h8,   1, 32'h8,   m(32'h4));
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog");
        end
    end

endmodule
